// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-map constants, FSM state type and port ids for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam logic [15:0] ROM_LIMIT_DEF = 16'h0100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Winner selection between CPU and DMA ports with a starvation guard for the DMA port.
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic idle,
    input  logic grant,
    input  logic grant_port,
    output logic winner
);

    localparam int unsigned HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_d, hold_q;

    // CPU wins unless it is not requesting or the DMA has been held off MAX_HOLD times
    always_comb begin
        winner = PORT_CPU;
        if (!req0 || (req1 && (hold_q == HW'(MAX_HOLD)))) begin
            winner = PORT_DMA;
        end
    end

    // Count CPU grants made while the DMA waits; clear on DMA grant or when the DMA stops asking
    always_comb begin
        hold_d = hold_q;
        if (idle) begin
            if (!req1) begin
                hold_d = '0;
            end else if (grant) begin
                if (grant_port == PORT_DMA) begin
                    hold_d = '0;
                end else if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
        end
    end

    // Hold counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: CPU priority, ROM write rejection, region wait states.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [15:0] ROM_LIMIT = ROM_LIMIT_DEF,
    parameter int unsigned ROM_WAIT  = 0,
    parameter int unsigned RAM_WAIT  = 1,
    parameter int unsigned MAX_HOLD  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        owner,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_read,
    output logic        mem_write
);

    localparam int unsigned WMAX = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
    localparam int unsigned WW   = (WMAX < 2) ? 1 : $clog2(WMAX + 1);

    state_e        state_d, state_q;
    logic [WW-1:0] wcnt_d, wcnt_q;
    logic          we_d, we_q;
    logic          ack0_d, ack0_q, ack1_d, ack1_q;
    logic [7:0]    rdata_d, rdata_q;
    logic          err_d, err_q;
    logic          owner_d, owner_q;
    logic          busy_d, busy_q;
    logic [15:0]   mem_addr_d, mem_addr_q;
    logic [7:0]    mem_wdata_d, mem_wdata_q;
    logic          mem_read_d, mem_read_q;
    logic          mem_write_d, mem_write_q;

    logic          idle, grant, winner;
    logic          sel_we, in_rom;
    logic [15:0]   sel_addr;
    logic [7:0]    sel_wdata;

    assign idle  = (state_q == ST_IDLE);
    assign grant = idle && (req0 || req1);

    mem_arb_pick #(
        .MAX_HOLD (MAX_HOLD)
    ) u_pick (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .idle       (idle),
        .grant      (grant),
        .grant_port (winner),
        .winner     (winner)
    );

    // Next-state and registered-output computation; outputs are set one edge ahead of the
    // cycle they belong to, so mem_write is raised when entering the last ACCESS cycle
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        we_d        = we_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        sel_we      = (winner == PORT_DMA) ? we1 : we0;
        sel_addr    = (winner == PORT_DMA) ? addr1 : addr0;
        sel_wdata   = (winner == PORT_DMA) ? wdata1 : wdata0;
        in_rom      = (sel_addr < ROM_LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d     = winner;
                    we_d        = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    if (sel_we && in_rom) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        ack0_d  = (winner == PORT_CPU);
                        ack1_d  = (winner == PORT_DMA);
                    end else begin
                        state_d     = ST_ACCESS;
                        wcnt_d      = in_rom ? WW'(ROM_WAIT) : WW'(RAM_WAIT);
                        mem_read_d  = !sel_we;
                        mem_write_d = sel_we && (wcnt_d == '0);
                    end
                end
            end
            ST_ACCESS: begin
                if (wcnt_q != '0) begin
                    wcnt_d      = wcnt_q - WW'(1);
                    mem_read_d  = !we_q;
                    mem_write_d = we_q && (wcnt_q == WW'(1));
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                    ack0_d  = (owner_q == PORT_CPU);
                    ack1_d  = (owner_q == PORT_DMA);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            we_q        <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            we_q        <= we_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule
